// File: rtl/interpolator_nx.sv
// Upsamples CHANNELS parallel streams by RATIO using per-channel linear or
// zero-order-hold interpolation, with one output sample per fast strobe.

module interpolator_nx_lane #(
  parameter int WIDTH       = 8,
  parameter int RATIO       = 10,
  parameter int SIGNED_DATA = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             ovr,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int RW = $clog2(RATIO) + 1;
  localparam int DW = WIDTH + 1 + RW;
  localparam logic [RW-1:0] R_C = RW'(RATIO);
  localparam logic [DW-1:0] R_D = DW'(RATIO);

  logic [WIDTH-1:0] x0, x1, x0_e, x1_e;
  logic [WIDTH:0]   q, qd, q_e, qd_e, q_nx, qd_new, d_new, mag, y_lin;
  logic [RW-1:0]    r, rd, r_e, rd_e, r_nx, rd_new, r_sum;
  logic             neg, neg_e, neg_new;

  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
    return (SIGNED_DATA != 0) ? {v[WIDTH-1], v} : {1'b0, v};
  endfunction

  // Difference of the incoming segment (new x1 minus new x0 = old x1),
  // split once into quotient/remainder by the constant RATIO.
  assign d_new   = ext(din) - ext(x1);
  assign neg_new = d_new[WIDTH];
  assign mag     = neg_new ? -d_new : d_new;
  assign qd_new  = (WIDTH+1)'({{RW{1'b0}}, mag} / R_D);
  assign rd_new  = RW'({{RW{1'b0}}, mag} % R_D);

  // A coincident load makes the new segment visible to this cycle's emit.
  assign x0_e  = load ? x1     : x0;
  assign x1_e  = load ? din    : x1;
  assign qd_e  = load ? qd_new : qd;
  assign rd_e  = load ? rd_new : rd;
  assign neg_e = load ? neg_new : neg;
  assign q_e   = load ? '0     : q;
  assign r_e   = load ? '0     : r;

  assign y_lin = ext(x0_e) + (neg_e ? -q_e : q_e);
  assign r_sum = r_e + rd_e;

  always_comb begin
    q_nx = q_e + qd_e;
    r_nx = r_sum;
    if (r_sum >= R_C) begin
      q_nx = q_e + qd_e + (WIDTH+1)'(1);
      r_nx = r_sum - R_C;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0   <= '0;
      x1   <= '0;
      qd   <= '0;
      rd   <= '0;
      neg  <= 1'b0;
      q    <= '0;
      r    <= '0;
      dout <= '0;
    end else begin
      if (load) begin
        x0  <= x1;
        x1  <= din;
        qd  <= qd_new;
        rd  <= rd_new;
        neg <= neg_new;
        q   <= '0;
        r   <= '0;
      end
      if (step) begin
        q    <= q_nx;
        r    <= r_nx;
        dout <= mode ? y_lin[WIDTH-1:0] : x0_e;
      end else if (ovr) begin
        dout <= x1_e;
      end
    end
  end
endmodule

module interpolator_nx #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 1,
  parameter int RATIO       = 10,
  parameter int SIGNED_DATA = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      clk_en_nx,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      underrun_clr,
  output logic [CHANNELS*WIDTH-1:0] sample_out,
  output logic                      out_valid,
  output logic                      end_stage,
  output logic                      underrun
);
  localparam int PW = $clog2(RATIO + 1);
  localparam logic [PW-1:0] PH_END  = PW'(RATIO);
  localparam logic [PW-1:0] PH_LAST = PW'(RATIO - 1);

  logic [PW-1:0] phase, ph_eff;
  logic          ovr, step;
  logic [CHANNELS-1:0][WIDTH-1:0] din, dout;

  assign ph_eff = clk_en ? '0 : phase;
  // Strobe past the end of a segment: hold x1, phase stays saturated.
  assign ovr    = clk_en_nx && (ph_eff == PH_END);
  assign step   = clk_en_nx && !ovr;

  assign din        = sample_in;
  assign sample_out = dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      out_valid <= 1'b0;
      end_stage <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (step)
        phase <= ph_eff + PW'(1);
      else if (clk_en)
        phase <= '0;
      out_valid <= clk_en_nx;
      end_stage <= step && (ph_eff == PH_LAST);
      if (ovr)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    interpolator_nx_lane #(
      .WIDTH      (WIDTH),
      .RATIO      (RATIO),
      .SIGNED_DATA(SIGNED_DATA)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .load (clk_en),
      .step (step),
      .ovr  (ovr),
      .mode (mode),
      .din  (din[c]),
      .dout (dout[c])
    );
  end
endmodule
